// File: rtl/latch_response_checker_if.sv
// Signal bundle between a latch/flip-flop lab UUT harness and its response checker.
// Inputs are sampled every clk edge; err/compl_err are one-cycle strobes, counters are level values.
interface latch_response_checker_if #(
  parameter int CNT_W = 16
);
  logic             en;
  logic             c;
  logic             d;
  logic             s;
  logic             r;
  logic             q;
  logic             qn;
  logic             exp_q;
  logic             exp_valid;
  logic             err;
  logic             compl_err;
  logic [CNT_W-1:0] mismatch_cnt;
  logic [CNT_W-1:0] compl_cnt;
  logic [CNT_W-1:0] forbid_cnt;
  logic [CNT_W-1:0] sample_cnt;

  modport master (
    output en, c, d, s, r, q, qn,
    input  exp_q, exp_valid, err, compl_err,
    input  mismatch_cnt, compl_cnt, forbid_cnt, sample_cnt
  );

  modport slave (
    input  en, c, d, s, r, q, qn,
    output exp_q, exp_valid, err, compl_err,
    output mismatch_cnt, compl_cnt, forbid_cnt, sample_cnt
  );
endinterface

// File: rtl/latch_response_checker.sv
// Cycle-accurate reference model of a D latch / T FF / SR FF that scores a UUT's Q/Qn
// against it, with a settle window after stimulus changes and saturating event counters.
module latch_response_checker #(
  parameter int MODE   = 0,
  parameter int CNT_W  = 16,
  parameter int SETTLE = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  latch_response_checker_if.slave  bus
);

  typedef enum logic [1:0] {
    M_UNKNOWN = 2'd0,
    M_ZERO    = 2'd1,
    M_ONE     = 2'd2
  } model_t;

  model_t           state;
  model_t           state_nxt;

  logic             c_s, d_s, s_s, r_s, q_s, qn_s;
  logic [3:0]       stim_prev;
  logic [3:0]       settle;
  logic [3:0]       settle_nxt;
  logic             err_r;
  logic             compl_err_r;
  logic [CNT_W-1:0] mismatch_cnt_r;
  logic [CNT_W-1:0] compl_cnt_r;
  logic [CNT_W-1:0] forbid_cnt_r;
  logic [CNT_W-1:0] sample_cnt_r;

  logic [3:0]       stim_s;
  logic             c_prev_s;
  logic             rise;
  logic             defining;
  logic             forbid;
  logic             adopt;
  logic             quiet;
  logic             q_bad;
  logic             do_cmp;
  logic             do_compl;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign stim_s   = {c_s, d_s, s_s, r_s};
  assign c_prev_s = stim_prev[3];
  assign rise     = c_s & ~c_prev_s;

  always_comb begin
    state_nxt  = state;
    defining   = 1'b0;
    forbid     = 1'b0;
    adopt      = 1'b0;
    settle_nxt = 4'd0;
    case (MODE)
      0: begin
        if (c_s) begin
          defining  = 1'b1;
          state_nxt = d_s ? M_ONE : M_ZERO;
        end
      end
      1: begin
        if (rise && d_s && (state != M_UNKNOWN))
          state_nxt = (state == M_ONE) ? M_ZERO : M_ONE;
      end
      default: begin
        if (rise && (s_s || r_s)) begin
          defining = 1'b1;
          if (s_s && r_s) begin
            state_nxt = M_UNKNOWN;
            forbid    = 1'b1;
          end else begin
            state_nxt = s_s ? M_ONE : M_ZERO;
          end
        end
      end
    endcase
    // An unknown model trusts a UUT that shows complementary outputs.
    if ((state == M_UNKNOWN) && !defining && (q_s != qn_s)) begin
      adopt     = 1'b1;
      state_nxt = q_s ? M_ONE : M_ZERO;
    end
    if (stim_s != stim_prev)
      settle_nxt = 4'(SETTLE);
    else if (settle != 4'd0)
      settle_nxt = settle - 4'd1;
  end

  assign quiet    = (settle_nxt == 4'd0);
  assign q_bad    = (q_s != (state_nxt == M_ONE));
  assign do_cmp   = bus.en && (state_nxt != M_UNKNOWN) && quiet && !adopt;
  assign do_compl = bus.en && quiet && (q_s == qn_s);

  always_ff @(posedge clk) begin
    if (rst) state <= M_UNKNOWN;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c_s            <= 1'b0;
      d_s            <= 1'b0;
      s_s            <= 1'b0;
      r_s            <= 1'b0;
      q_s            <= 1'b0;
      qn_s           <= 1'b0;
      stim_prev      <= 4'd0;
      settle         <= 4'd0;
      err_r          <= 1'b0;
      compl_err_r    <= 1'b0;
      mismatch_cnt_r <= '0;
      compl_cnt_r    <= '0;
      forbid_cnt_r   <= '0;
      sample_cnt_r   <= '0;
    end else begin
      c_s         <= bus.c;
      d_s         <= bus.d;
      s_s         <= bus.s;
      r_s         <= bus.r;
      q_s         <= bus.q;
      qn_s        <= bus.qn;
      stim_prev   <= stim_s;
      settle      <= settle_nxt;
      err_r       <= do_cmp && q_bad;
      compl_err_r <= do_compl;
      if (do_cmp)          sample_cnt_r   <= sat_inc(sample_cnt_r);
      if (do_cmp && q_bad) mismatch_cnt_r <= sat_inc(mismatch_cnt_r);
      if (do_compl)        compl_cnt_r    <= sat_inc(compl_cnt_r);
      // Forbidden SR captures are a property of the stimulus, so they count regardless of en.
      if (forbid)          forbid_cnt_r   <= sat_inc(forbid_cnt_r);
    end
  end

  assign bus.exp_q        = (state == M_ONE);
  assign bus.exp_valid    = (state != M_UNKNOWN);
  assign bus.err          = err_r;
  assign bus.compl_err    = compl_err_r;
  assign bus.mismatch_cnt = mismatch_cnt_r;
  assign bus.compl_cnt    = compl_cnt_r;
  assign bus.forbid_cnt   = forbid_cnt_r;
  assign bus.sample_cnt   = sample_cnt_r;

endmodule

// File: tb/tb_latch_response_checker.sv
// Bench for latch_response_checker: D latch (16- and 2-bit counters), T FF and SR FF instances
// driven by directed vectors; expected pulses and model states are queued and popped by monitors.
module tb_latch_response_checker;

  logic clk = 1'b0;
  logic rst0, rst1, rst2;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic lq0     = 1'b0;
  logic tq1     = 1'b0;

  always #5 clk = ~clk;

  latch_response_checker_if #(.CNT_W(16)) if0 ();
  latch_response_checker_if #(.CNT_W(16)) if1 ();
  latch_response_checker_if #(.CNT_W(16)) if2 ();
  latch_response_checker_if #(.CNT_W(2))  if3 ();

  latch_response_checker #(.MODE(0), .CNT_W(16), .SETTLE(2)) u0 (.clk(clk), .rst(rst0), .bus(if0.slave));
  latch_response_checker #(.MODE(1), .CNT_W(16), .SETTLE(2)) u1 (.clk(clk), .rst(rst1), .bus(if1.slave));
  latch_response_checker #(.MODE(2), .CNT_W(16), .SETTLE(2)) u2 (.clk(clk), .rst(rst2), .bus(if2.slave));
  latch_response_checker #(.MODE(0), .CNT_W(2),  .SETTLE(2)) u3 (.clk(clk), .rst(rst0), .bus(if3.slave));

  // The narrow-counter D latch checker watches exactly the same UUT as u0.
  assign if3.en = if0.en;
  assign if3.c  = if0.c;
  assign if3.d  = if0.d;
  assign if3.s  = if0.s;
  assign if3.r  = if0.r;
  assign if3.q  = if0.q;
  assign if3.qn = if0.qn;

  // Scoreboard queues: counter value expected at each err/compl_err pulse, and model-state sequences.
  logic [15:0] exp_mm0_q[$];
  logic [1:0]  exp_mm3_q[$];
  logic [15:0] exp_cp0_q[$];
  logic [1:0]  exp_cp3_q[$];
  logic [1:0]  exp_st1_q[$];
  logic [1:0]  exp_st2_q[$];
  logic [1:0]  last1, last2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Ideal D latch UUT.
  task automatic drv0(input logic cc, input logic dd);
    if (cc) lq0 = dd;
    if0.c = cc; if0.d = dd; if0.q = lq0; if0.qn = ~lq0;
  endtask

  task automatic set_q0(input logic qq, input logic qnn);
    if0.q = qq; if0.qn = qnn;
  endtask

  task automatic drv2(input logic cc, input logic ss, input logic rr, input logic qq, input logic qnn);
    if2.c = cc; if2.s = ss; if2.r = rr; if2.q = qq; if2.qn = qnn;
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (!rst0 && if0.err) begin
      if (exp_mm0_q.size() == 0) check("u0 unexpected err", 32'(if0.err), 0);
      else check("u0 mismatch_cnt at err", 32'(if0.mismatch_cnt), 32'(exp_mm0_q.pop_front()));
    end
    if (!rst0 && if3.err) begin
      if (exp_mm3_q.size() == 0) check("u3 unexpected err", 32'(if3.err), 0);
      else check("u3 mismatch_cnt at err", 32'(if3.mismatch_cnt), 32'(exp_mm3_q.pop_front()));
    end
    if (!rst0 && if0.compl_err) begin
      if (exp_cp0_q.size() == 0) check("u0 unexpected compl_err", 32'(if0.compl_err), 0);
      else check("u0 compl_cnt at compl_err", 32'(if0.compl_cnt), 32'(exp_cp0_q.pop_front()));
    end
    if (!rst0 && if3.compl_err) begin
      if (exp_cp3_q.size() == 0) check("u3 unexpected compl_err", 32'(if3.compl_err), 0);
      else check("u3 compl_cnt at compl_err", 32'(if3.compl_cnt), 32'(exp_cp3_q.pop_front()));
    end
    if (!rst1 && (if1.err || if1.compl_err)) check("u1 unexpected err", 32'({if1.err, if1.compl_err}), 0);
    if (!rst2 && (if2.err || if2.compl_err)) check("u2 unexpected err", 32'({if2.err, if2.compl_err}), 0);
  end

  always @(negedge clk) begin
    if (rst1) last1 = 2'b00;
    else if ({if1.exp_valid, if1.exp_q} !== last1) begin
      if (exp_st1_q.size() == 0) check("u1 unexpected model change", 32'({if1.exp_valid, if1.exp_q}), 32'(last1));
      else check("u1 {exp_valid,exp_q}", 32'({if1.exp_valid, if1.exp_q}), 32'(exp_st1_q.pop_front()));
      last1 = {if1.exp_valid, if1.exp_q};
    end
    if (rst2) last2 = 2'b00;
    else if ({if2.exp_valid, if2.exp_q} !== last2) begin
      if (exp_st2_q.size() == 0) check("u2 unexpected model change", 32'({if2.exp_valid, if2.exp_q}), 32'(last2));
      else check("u2 {exp_valid,exp_q}", 32'({if2.exp_valid, if2.exp_q}), 32'(exp_st2_q.pop_front()));
      last2 = {if2.exp_valid, if2.exp_q};
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] d_tab;
    d_tab = 16'b1011_0010_1110_0101;
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    if0.en = 1'b0; if0.s = 1'b0; if0.r = 1'b0;
    drv0(1'b0, 1'b0);
    if1.en = 1'b0; if1.c = 1'b0; if1.d = 1'b1; if1.s = 1'b0; if1.r = 1'b0; if1.q = 1'b0; if1.qn = 1'b1;
    if2.en = 1'b0; if2.d = 1'b0;
    drv2(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(3);

    // D latch: reset state, then ideal UUT across a directed D/C pattern.
    rst0 = 1'b0;
    step(1);
    check("u0 reset exp_valid", 32'(if0.exp_valid), 0);
    check("u0 reset mismatch_cnt", 32'(if0.mismatch_cnt), 0);
    check("u0 reset sample_cnt", 32'(if0.sample_cnt), 0);
    check("u3 reset compl_cnt", 32'(if3.compl_cnt), 0);
    step(3);
    if0.en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drv0(1'((i / 2) % 2), d_tab[i]);
      step(6);
    end
    check("u0 ideal mismatch_cnt", 32'(if0.mismatch_cnt), 0);
    check("u0 ideal compl_cnt", 32'(if0.compl_cnt), 0);
    check("u0 ideal sample_cnt>0", 32'(if0.sample_cnt != 0), 1);
    check("u0 exp_valid after run", 32'(if0.exp_valid), 1);

    // Q stuck at 0 while C=1,D=1 for five settled samples; the 2-bit copy saturates at 3.
    drv0(1'b1, 1'b1);
    step(5);
    for (int k = 1; k <= 5; k++) begin
      exp_mm0_q.push_back(16'(k));
      exp_mm3_q.push_back((k > 3) ? 2'd3 : 2'(k));
    end
    set_q0(1'b0, 1'b1);
    step(5);
    set_q0(1'b1, 1'b0);
    step(3);
    check("u0 exp_q holds 1", 32'(if0.exp_q), 1);

    // Q == Qn for three settled samples while latch is closed.
    drv0(1'b0, 1'b1);
    step(5);
    for (int k = 1; k <= 3; k++) begin
      exp_cp0_q.push_back(16'(k));
      exp_cp3_q.push_back(2'(k));
    end
    set_q0(1'b1, 1'b1);
    step(3);
    set_q0(1'b1, 1'b0);
    step(3);
    check("u0 mismatch_cnt after stuck", 32'(if0.mismatch_cnt), 5);
    check("u3 mismatch_cnt saturated", 32'(if3.mismatch_cnt), 3);
    check("u0 compl_cnt", 32'(if0.compl_cnt), 3);
    check("u3 compl_cnt", 32'(if3.compl_cnt), 3);

    // en=0: bad outputs must neither pulse nor count; en back on keeps counters.
    if0.en = 1'b0;
    step(1);
    set_q0(1'b0, 1'b0);
    step(4);
    set_q0(1'b1, 1'b0);
    step(3);
    if0.en = 1'b1;
    step(4);
    check("u0 mismatch_cnt across en=0", 32'(if0.mismatch_cnt), 5);
    check("u0 compl_cnt across en=0", 32'(if0.compl_cnt), 3);

    // Mid-run reset clears everything.
    if0.en = 1'b0;
    rst0 = 1'b1;
    step(1);
    rst0 = 1'b0;
    check("u0 post-rst mismatch_cnt", 32'(if0.mismatch_cnt), 0);
    check("u0 post-rst compl_cnt", 32'(if0.compl_cnt), 0);
    check("u0 post-rst sample_cnt", 32'(if0.sample_cnt), 0);
    check("u0 post-rst exp_valid", 32'(if0.exp_valid), 0);
    check("u3 post-rst mismatch_cnt", 32'(if3.mismatch_cnt), 0);
    step(2);

    // T flip-flop, T=1: adopt Q=0, then four rising C edges.
    exp_st1_q.push_back(2'b10);
    exp_st1_q.push_back(2'b11);
    exp_st1_q.push_back(2'b10);
    exp_st1_q.push_back(2'b11);
    exp_st1_q.push_back(2'b10);
    rst1 = 1'b0;
    step(4);
    if1.en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tq1 = ~tq1;
      if1.c = 1'b1; if1.q = tq1; if1.qn = ~tq1;
      step(4);
      if1.c = 1'b0;
      step(4);
    end
    check("u1 final exp_q", 32'(if1.exp_q), 0);
    check("u1 mismatch_cnt", 32'(if1.mismatch_cnt), 0);
    check("u1 sample_cnt>0", 32'(if1.sample_cnt != 0), 1);

    // SR flip-flop: adopt, forbidden S=R=1, then set and reset edges.
    exp_st2_q.push_back(2'b10);
    exp_st2_q.push_back(2'b00);
    exp_st2_q.push_back(2'b11);
    exp_st2_q.push_back(2'b10);
    rst2 = 1'b0;
    step(4);
    if2.en = 1'b1;
    step(3);
    if2.en = 1'b0;
    drv2(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    step(4);
    check("u2 forbid_cnt", 32'(if2.forbid_cnt), 1);
    check("u2 exp_valid after forbid", 32'(if2.exp_valid), 0);
    drv2(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    step(4);
    drv2(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(4);
    check("u2 exp_q after set", 32'(if2.exp_q), 1);
    if2.en = 1'b1;
    step(3);
    drv2(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(4);
    drv2(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    step(4);
    drv2(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    step(4);
    check("u2 forbid_cnt final", 32'(if2.forbid_cnt), 1);
    check("u2 mismatch_cnt", 32'(if2.mismatch_cnt), 0);
    check("u2 sample_cnt>0", 32'(if2.sample_cnt != 0), 1);

    // Every queued expectation must have been consumed by a DUT event.
    check("u0 err pulses missing", 32'(exp_mm0_q.size()), 0);
    check("u3 err pulses missing", 32'(exp_mm3_q.size()), 0);
    check("u0 compl pulses missing", 32'(exp_cp0_q.size()), 0);
    check("u3 compl pulses missing", 32'(exp_cp3_q.size()), 0);
    check("u1 model changes missing", 32'(exp_st1_q.size()), 0);
    check("u2 model changes missing", 32'(exp_st2_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
